branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 132 +++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped table of 2-bit saturating counters indexed by pc[IDX_W+1:2].
// Lookups are combinational. Updates train the indexed counter at the next clock edge.
// mispredict is registered one cycle after each update.
// Optional statistics counters are enabled by defining BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [2:0]  upd_br_sel,
    input  logic        upd_taken,
    input  logic        upd_pred,
    output logic        mispredict
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
`endif
);

    localparam int ENTRIES = 1 << IDX_W;

    // Counter encoding: the MSB is the predicted direction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } counterState_e;

    counterState_e counterTable_q [ENTRIES];
    counterState_e counterTable_d [ENTRIES];
    counterState_e trainedCounter;
    logic          mispredict_q;
    logic          mispredict_d;

    logic [IDX_W-1:0] lookupIdx;
    logic [IDX_W-1:0] updIdx;
    logic             updIsConditional;
    logic             updTrain;
    logic             updMismatch;

    // PC bits outside the index field only cause aliasing, so they are deliberately dropped.
    logic unusedPcBits;
    assign unusedPcBits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                            upd_pc[31:IDX_W+2], upd_pc[1:0]};

    assign lookupIdx   = lookup_pc[IDX_W+1:2];
    assign updIdx      = upd_pc[IDX_W+1:2];
    assign updMismatch = upd_taken ^ upd_pred;
    assign updTrain    = upd_valid && updIsConditional;

    // Unconditional (010) and never (111) branch types carry no direction history worth learning.
    always_comb begin
        updIsConditional = 1'b1;
        case (upd_br_sel)
            3'b010:  updIsConditional = 1'b0;
            3'b111:  updIsConditional = 1'b0;
            default: updIsConditional = 1'b1;
        endcase
    end

    // The lookup reads the registered table, so a same-cycle update to the same entry is not visible yet.
    assign pred_taken = lookup_valid && counterTable_q[lookupIdx][1];

    // Compute the saturating increment or decrement of the entry being trained.
    always_comb begin
        trainedCounter = counterTable_q[updIdx];
        case (counterTable_q[updIdx])
            SNT:     trainedCounter = upd_taken ? WNT : SNT;
            WNT:     trainedCounter = upd_taken ? WT  : SNT;
            WT:      trainedCounter = upd_taken ? ST  : WNT;
            ST:      trainedCounter = upd_taken ? ST  : WT;
            default: trainedCounter = WNT;
        endcase
    end

    // Build the next table image with only the trained entry changed.
    always_comb begin
        counterTable_d = counterTable_q;
        if (updTrain) begin
            counterTable_d[updIdx] = trainedCounter;
        end
    end

    // Mispredict is flagged for every valid update, whatever the branch type.
    assign mispredict_d = upd_valid && updMismatch;

    // Reset forces every entry to weakly-not-taken and drops any update presented on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counterTable_q[i] <= WNT;
            end
            mispredict_q <= 1'b0;
        end else begin
            counterTable_q <= counterTable_d;
            mispredict_q   <= mispredict_d;
        end
    end

    assign mispredict = mispredict_q;

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] brCount_q;
    logic [31:0] mispredCount_q;

    // Statistics counters advance on the same edge as training and wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            brCount_q      <= 32'd0;
            mispredCount_q <= 32'd0;
        end else begin
            if (updTrain) begin
                brCount_q <= brCount_q + 32'd1;
            end
            if (mispredict_d) begin
                mispredCount_q <= mispredCount_q + 32'd1;
            end
        end
    end

    assign br_count      = brCount_q;
    assign mispred_count = mispredCount_q;
`endif

endmodule
